// File: rtl/gpio_pad_config.sv
// Core-side GPIO pad control: serial-loaded per-pad configuration with atomic commit,
// registered pad output data and two-flop synchronised pad input data.
module gpio_pad_config #(
  parameter int         NUM_PADS  = 46,
  parameter int         CFG_BITS  = 8,
  parameter logic [7:0] RESET_CFG = 8'h0A
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic                cfg_data,
  output logic                cfg_ready,
  input  logic                cfg_commit,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [NUM_PADS-1:0] core_out,
  output logic [NUM_PADS-1:0] core_in,
  output logic [NUM_PADS-1:0] bidir_OE,
  output logic [NUM_PADS-1:0] bidir_IE,
  output logic [NUM_PADS-1:0] bidir_PU,
  output logic [NUM_PADS-1:0] bidir_PD,
  output logic [NUM_PADS-1:0] bidir_CS,
  output logic [NUM_PADS-1:0] bidir_SL,
  output logic [NUM_PADS-1:0] bidir_PDRV0,
  output logic [NUM_PADS-1:0] bidir_PDRV1,
  output logic [NUM_PADS-1:0] bidir_A,
  input  logic [NUM_PADS-1:0] bidir_Y
);

  localparam int TOTAL = NUM_PADS * CFG_BITS;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam int F_OE    = 0;
  localparam int F_IE    = 1;
  localparam int F_PU    = 2;
  localparam int F_PD    = 3;
  localparam int F_CS    = 4;
  localparam int F_SL    = 5;
  localparam int F_PDRV0 = 6;
  localparam int F_PDRV1 = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [TOTAL-1:0]   r_shreg;
  logic [TOTAL-1:0]   r_active;
  logic               r_done;
  logic               r_err;
  logic [NUM_PADS-1:0] r_a;
  logic [NUM_PADS-1:0] r_sync1;
  logic [NUM_PADS-1:0] r_sync2;

  logic w_full;
  logic w_accept;
  logic w_last;
  logic w_commit_ok;
  logic w_commit_err;

  // Qualify chain events; a commit always wins over a same-cycle bit.
  always_comb begin
    w_full       = (r_state == S_FULL);
    w_accept     = cfg_valid & ~w_full & ~cfg_commit;
    w_last       = (r_cnt == CW'(TOTAL - 1));
    w_commit_ok  = cfg_commit & w_full;
    w_commit_err = cfg_commit & ~w_full;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_commit) begin
          w_next_state = S_IDLE;
        end else if (cfg_valid) begin
          w_next_state = w_last ? S_FULL : S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cfg_commit) begin
          w_next_state = S_IDLE;
        end else if (cfg_valid && w_last) begin
          w_next_state = S_FULL;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_FULL: begin
        if (cfg_commit) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_FULL;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cfg_ready = (r_state != S_FULL);
  end

  // Shift chain and accepted-bit counter; a failed commit also flushes the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (cfg_commit) begin
      r_cnt <= '0;
      if (!w_full) begin
        r_shreg <= '0;
      end else begin
        r_shreg <= r_shreg;
      end
    end else if (w_accept) begin
      r_shreg <= {cfg_data, r_shreg[TOTAL-1:1]};
      r_cnt   <= r_cnt + CW'(1);
    end else begin
      r_cnt   <= r_cnt;
      r_shreg <= r_shreg;
    end
  end

  // Active configuration image, replaced atomically on a successful commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= {NUM_PADS{RESET_CFG}};
    end else if (w_commit_ok) begin
      r_active <= r_shreg;
    end else begin
      r_active <= r_active;
    end
  end

  // Commit status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_commit_ok;
      r_err  <= w_commit_err;
    end
  end

  // Pad data path: output register and two-flop input synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_a     <= core_out;
      r_sync1 <= bidir_Y;
      r_sync2 <= r_sync1;
    end
  end

  // Fan the packed per-pad words out to the pad control buses.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      bidir_OE[p]    = r_active[p*CFG_BITS + F_OE];
      bidir_IE[p]    = r_active[p*CFG_BITS + F_IE];
      bidir_PU[p]    = r_active[p*CFG_BITS + F_PU];
      bidir_PD[p]    = r_active[p*CFG_BITS + F_PD];
      bidir_CS[p]    = r_active[p*CFG_BITS + F_CS];
      bidir_SL[p]    = r_active[p*CFG_BITS + F_SL];
      bidir_PDRV0[p] = r_active[p*CFG_BITS + F_PDRV0];
      bidir_PDRV1[p] = r_active[p*CFG_BITS + F_PDRV1];
    end
  end

  // Registered outputs to core and pads; input data is gated by the pad's IE.
  always_comb begin
    cfg_done = r_done;
    cfg_err  = r_err;
    bidir_A  = r_a;
    core_in  = r_sync2 & bidir_IE;
  end

endmodule
